// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - command-driven J/K excitation controller for an external JK flip-flop bank
module jk_bank_driver #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] target,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_RESP} state_t;

    state_t            r_state, w_state_nx;
    logic [WIDTH-1:0]  r_j, r_k, r_target;
    logic [WIDTH-1:0]  w_j_nx, w_k_nx, w_target_nx;
    logic              r_err, w_err_nx;
    logic [RW-1:0]     r_retry, w_retry_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_j      <= '0;
            r_k      <= '0;
            r_target <= '0;
            r_err    <= 1'b0;
            r_retry  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_j      <= w_j_nx;
            r_k      <= w_k_nx;
            r_target <= w_target_nx;
            r_err    <= w_err_nx;
            r_retry  <= w_retry_nx;
        end
    end

    // j/k are computed one state ahead so they are registered during DRIVE;
    // q_in is the snapshot "cur" at accept and at every failed check.
    always_comb begin
        w_state_nx  = r_state;
        w_j_nx      = '0;
        w_k_nx      = '0;
        w_target_nx = r_target;
        w_err_nx    = r_err;
        w_retry_nx  = r_retry;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_err_nx   = 1'b0;
                    w_state_nx = S_DRIVE;
                    case (req_op)
                        3'd0: w_target_nx = q_in;
                        3'd1: begin
                            w_target_nx = q_in | req_data;
                            w_j_nx      = req_data;
                        end
                        3'd2: begin
                            w_target_nx = q_in & ~req_data;
                            w_k_nx      = req_data;
                        end
                        3'd3: begin
                            w_target_nx = q_in ^ req_data;
                            w_j_nx      = req_data;
                            w_k_nx      = req_data;
                        end
                        3'd4: begin
                            w_target_nx = req_data;
                            w_j_nx      = ~q_in & req_data;
                            w_k_nx      = q_in & ~req_data;
                        end
                        default: begin
                            w_err_nx   = 1'b1;
                            w_state_nx = S_RESP;
                        end
                    endcase
                end
            end
            S_DRIVE: w_state_nx = S_CHECK;
            S_CHECK: begin
                if (q_in == r_target) begin
                    w_state_nx = S_RESP;
                end else if (r_retry < MAX_R) begin
                    w_retry_nx = r_retry + 1'b1;
                    w_j_nx     = ~q_in & r_target;
                    w_k_nx     = q_in & ~r_target;
                    w_state_nx = S_DRIVE;
                end else begin
                    w_err_nx   = 1'b1;
                    w_state_nx = S_RESP;
                end
            end
            S_RESP: begin
                w_retry_nx = '0;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_RESP);
    assign err       = (r_state == S_RESP) && r_err;
    assign j         = r_j;
    assign k         = r_k;
    assign target    = r_target;
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - randomized self-checking bench for jk_bank_driver with a JK bank model
module tb_jk_bank_driver;
    localparam int W  = 8;
    localparam int MR = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_data;
    logic [W-1:0] j, k, target;
    logic         busy, done, err;

    logic [W-1:0] bank = '0;
    logic [W-1:0] nxt;
    logic [W-1:0] stuck = '0;
    logic [W-1:0] glitch = '0;
    logic         arm_tok = 1'b0;
    logic         used_tok = 1'b0;
    logic [W-1:0] pre_val = '0;
    logic         pre_en = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .q_in(bank), .j(j), .k(k),
        .target(target), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank: stuck bits read 0, an armed glitch freezes bits for one drive.
    always @(posedge clk) begin
        if (pre_en) begin
            bank <= pre_val & ~stuck;
        end else begin
            nxt = (j & ~bank) | (~k & bank);
            if ((j | k) != '0 && arm_tok != used_tok) begin
                nxt = (nxt & ~glitch) | (bank & glitch);
                used_tok <= arm_tok;
            end
            bank <= nxt & ~stuck;
        end
    end

    task automatic set_bank(input logic [W-1:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] data, input string name);
        logic [W-1:0] b, t, r, ej, ek, g, j1, k1, got_t;
        int att, exp_lat, exp_nz, lat, nz;
        logic exp_err, got_err, conflict, bad_busy, rsv;
        b = bank; t = b; ej = '0; ek = '0; rsv = (op > 3'd4);
        case (op)
            3'd1: begin t = b | data; ej = data; end
            3'd2: begin t = b & ~data; ek = data; end
            3'd3: begin t = b ^ data; ej = data; ek = data; end
            3'd4: begin t = data; ej = ~b & data; ek = b & ~data; end
            default: ;
        endcase
        if (rsv) begin
            exp_err = 1'b1; exp_lat = 1; exp_nz = 0; r = b;
        end else begin
            g = ((ej | ek) != '0 && arm_tok != used_tok) ? glitch : '0;
            att = 1;
            r = ((t & ~g) | (b & g)) & ~stuck;
            while (r != t && att <= MR) begin
                att++;
                r = t & ~stuck;
            end
            exp_err = (r != t);
            exp_lat = 1 + 2 * att;
            exp_nz  = ((ej | ek) != '0) ? att : 0;
        end
        req_valid = 1'b1; req_op = op; req_data = data;
        @(posedge clk);
        lat = 0; nz = 0; conflict = 0; bad_busy = 0; got_err = 0; got_t = '0; j1 = '0; k1 = '0;
        for (int c = 1; c <= 20; c++) begin
            #1 req_op = 3'($urandom); req_data = W'($urandom);
            @(negedge clk);
            if (c == 1) begin j1 = j; k1 = k; end
            if ((j | k) != '0) nz++;
            if ((j & k) != '0 && op != 3'd3) conflict = 1;
            if (done) begin
                lat = c; got_err = err; got_t = target; req_valid = 1'b0;
                break;
            end
            if (!busy || req_ready) bad_busy = 1;
        end
        n_cmp++;
        if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
        n_cmp++;
        if (got_err !== exp_err) begin n_fail++; $display("FAIL %s err: got %0b want %0b", name, got_err, exp_err); end
        n_cmp++;
        if (nz !== exp_nz) begin n_fail++; $display("FAIL %s drive_count: got %0d want %0d", name, nz, exp_nz); end
        n_cmp++;
        if (j1 !== ej || k1 !== ek) begin n_fail++; $display("FAIL %s first_jk: got j=%h k=%h want j=%h k=%h", name, j1, k1, ej, ek); end
        if (!rsv) begin
            n_cmp++;
            if (got_t !== t) begin n_fail++; $display("FAIL %s target: got %h want %h", name, got_t, t); end
        end
        n_cmp++;
        if (conflict !== 1'b0 || bad_busy !== 1'b0) begin n_fail++; $display("FAIL %s jk_busy: got conflict=%0b badbusy=%0b want 0 0", name, conflict, bad_busy); end
        if (lat != 0) @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || req_ready !== 1'b1 || bank !== r) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%0b ready=%0b bank=%h want 0 1 %h", name, done, req_ready, bank, r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_data = '0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({j, k, target, busy, done, err} !== '0) begin
            n_fail++; $display("FAIL reset_outs: got j=%h k=%h t=%h b=%0b d=%0b e=%0b want all 0", j, k, target, busy, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_load();
        set_bank(8'h00);
        do_cmd(3'd4, 8'hA5, "load_a5");
    endtask

    task automatic test_set_clr_tog();
        set_bank(8'hF0);
        do_cmd(3'd1, 8'h0F, "set_0f");
        do_cmd(3'd2, 8'h81, "clr_81");
        do_cmd(3'd3, 8'hFF, "tog_ff");
        n_cmp++;
        if (bank !== 8'h81) begin n_fail++; $display("FAIL tog_bank: got %h want 81", bank); end
    endtask

    task automatic test_zero_mask();
        do_cmd(3'd1, 8'h00, "set_zero");
        do_cmd(3'd3, 8'h00, "tog_zero");
        do_cmd(3'd0, 8'h5A, "hold");
    endtask

    task automatic test_stuck();
        stuck = 8'h01;
        set_bank(8'h00);
        do_cmd(3'd4, 8'h01, "stuck_bit0");
        stuck = 8'h00;
    endtask

    task automatic test_retry_once();
        set_bank(8'h00);
        glitch = 8'h01; arm_tok = ~arm_tok;
        do_cmd(3'd4, 8'h01, "retry_once");
        glitch = 8'h00;
    endtask

    task automatic test_reserved();
        set_bank(8'h3C);
        do_cmd(3'd6, 8'hFF, "reserved6");
    endtask

    task automatic test_reset_mid();
        set_bank(8'h00);
        req_valid = 1'b1; req_op = 3'd4; req_data = 8'h3C;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (j !== 8'h3C) begin n_fail++; $display("FAIL mid_drive_j: got %h want 3c", j); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (j !== 8'h00 || k !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_jk: got j=%h k=%h busy=%0b want 00 00 0", j, k, busy);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || req_ready !== 1'b1 || bank !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset_after: got done=%0b ready=%0b bank=%h want 0 1 00", done, req_ready, bank);
        end
        do_cmd(3'd0, 8'h00, "hold_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) set_bank(W'($urandom));
            do_cmd(3'($urandom_range(0, 7)), W'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_set_clr_tog();
        test_zero_mask();
        test_stuck();
        test_retry_once();
        test_reserved();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
